somador_pipeline: RTL and testbench

- Parametrised, pipelined successor to the 4-bit combinational adder.
- Adds or subtracts two WIDTH-bit operands. Work is split into STAGES equal carry-chained chunks, one chunk per pipeline stage.
- Valid/ready handshake on both ends, with backpressure.
- Produces sum, carry-out and signed overflow. Used as the ALU add path in later sprints.

---
 rtl/somador_pipeline.sv | 106 ++++++++++
 tb/tb_somador_pipeline.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/somador_pipeline.sv
`timescale 1ns/1ps
// Pipelined add/subtract of two WIDTH-bit operands, one carry-chained C-bit chunk per stage.
// Latency: STAGES cycles from input handshake to out_valid; one beat per cycle.
// Backpressure: global stall -- in_ready = !out_valid || out_ready; all stages hold when low.
// Optional SOMADOR_SATURATE_EN: clamp sum to the signed limit on overflow.
module somador_pipeline #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int C   = WIDTH / STAGES;
    localparam int L   = STAGES - 1;
    localparam int MSB = WIDTH - 1;

    logic advance;

    // Stage k consumes src_*[k]: the input port for stage 0, stage k-1's registers otherwise.
    logic [WIDTH-1:0] src_a [STAGES];
    logic [WIDTH-1:0] src_b [STAGES];
    logic [WIDTH-1:0] src_s [STAGES];
    logic             src_c [STAGES];
    logic             src_v [STAGES];

    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic             v_q [STAGES];

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    assign src_a[0] = a;
    assign src_b[0] = sub ? ~b : b;
    assign src_s[0] = '0;
    assign src_c[0] = sub;
    assign src_v[0] = in_valid;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [C:0]       chunk;
        logic [WIDTH-1:0] s_d;

        assign chunk = {1'b0, src_a[k][k*C +: C]} + {1'b0, src_b[k][k*C +: C]}
                     + {{C{1'b0}}, src_c[k]};

        always_comb begin
            s_d            = src_s[k];
            s_d[k*C +: C]  = chunk[C-1:0];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end else if (advance) begin
                a_q[k] <= src_a[k];
                b_q[k] <= src_b[k];
                s_q[k] <= s_d;
                c_q[k] <= chunk[C];
                v_q[k] <= src_v[k];
            end
        end

        if (k > 0) begin : g_link
            assign src_a[k] = a_q[k-1];
            assign src_b[k] = b_q[k-1];
            assign src_s[k] = s_q[k-1];
            assign src_c[k] = c_q[k-1];
            assign src_v[k] = v_q[k-1];
        end
    end

    // Only the operand MSBs matter once the last chunk has been added.
    logic unused_opnd;
    assign unused_opnd = ^{a_q[L], b_q[L]};

    logic ovf_w;
    assign ovf_w = (a_q[L][MSB] == b_q[L][MSB]) && (s_q[L][MSB] != a_q[L][MSB]);

    assign out_valid = v_q[L];
    assign cout      = c_q[L];
    assign ovf       = ovf_w;

`ifdef SOMADOR_SATURATE_EN
    assign sum = ovf_w ? {a_q[L][MSB], {(WIDTH-1){~a_q[L][MSB]}}} : s_q[L];
`else
    assign sum = s_q[L];
`endif

endmodule

// File: tb/tb_somador_pipeline.sv
`timescale 1ns/1ps
// Scoreboarded random/directed bench for somador_pipeline (WIDTH=16, STAGES=4).
module tb_somador_pipeline;

    localparam int W = 16;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    always #5 clk = ~clk;

    somador_pipeline #(.WIDTH(W), .STAGES(S)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc;
        bit           strict;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rdy_mode = 0;
    bit   lat_strict = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic on whole operands.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s, input int acc, input bit strict);
        exp_t e;
        int   ux = int'(x);
        int   uy = int'(y);
        int   sx = int'($signed(x));
        int   sy = int'($signed(y));
        int   r  = s ? sx - sy : sx + sy;
        e.sum    = r[W-1:0];
        e.cout   = s ? (ux >= uy) : (ux + uy > 65535);
        e.ovf    = (r > 32767) || (r < -32768);
`ifdef SOMADOR_SATURATE_EN
        if (r > 32767)       e.sum = 16'h7FFF;
        else if (r < -32768) e.sum = 16'h8000;
`endif
        e.acc    = acc;
        e.strict = strict;
        return e;
    endfunction

    task automatic abort(input string nm);
        errors++;
        checks++;
        $display("FAIL %s: timeout waiting on DUT (cycle %0d)", nm, cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    endtask

    // Called at posedge+1; returns at the posedge+1 after acceptance.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        int n = 0;
        in_valid = 1'b1;
        a        = x;
        b        = y;
        sub      = s;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) abort("send");
        sb.push_back(model(x, y, s, cyc, lat_strict));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain_empty", sb.size(), 0);
        sb.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid(input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 50);
        if (!out_valid) abort(nm);
    endtask

    initial begin
        logic [31:0] r;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            r = $urandom;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = r[0];
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: handshake rule, hold stability and in-order scoreboard checks.
    initial begin
        exp_t         e;
        bit           stalled = 1'b0;
        logic [W-1:0] h_sum;
        logic         h_cout;
        logic         h_ovf;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
                if (stalled) begin
                    chk("hold_valid", 32'(out_valid), 32'd1);
                    chk("hold_sum", 32'(sum), 32'(h_sum));
                    chk("hold_flags", 32'({cout, ovf}), 32'({h_cout, h_ovf}));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got sum 0x%0h with nothing expected", sum);
                    end else begin
                        e = sb.pop_front();
                        chk("sum", 32'(sum), 32'(e.sum));
                        chk("cout", 32'(cout), 32'(e.cout));
                        chk("ovf", 32'(ovf), 32'(e.ovf));
                        if (e.strict) chk("latency", cyc - e.acc, S);
                    end
                end
                stalled = out_valid && !out_ready;
                h_sum   = sum;
                h_cout  = cout;
                h_ovf   = ovf;
            end
        end
    end

    initial begin
        logic [31:0] r1;
        logic [31:0] r2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        sub      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_sum", 32'(sum), 32'd0);
        chk("reset_flags", 32'({cout, ovf}), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        send(16'h0006, 16'h0001, 1'b0);
        drain(50);

        send(16'hFFFF, 16'h0001, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0);
        send(16'h0005, 16'h0007, 1'b1);
        send(16'h8000, 16'h0001, 1'b1);
        send(16'h8000, 16'h8000, 1'b0);
        send(16'h0000, 16'h0000, 1'b1);
        drain(50);

        for (int i = 0; i < 8; i++) send(16'(i), 16'h0100, 1'b0);
        drain(50);

        lat_strict = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(16'(i), 16'h0100, 1'b0);
            end
            begin
                wait_out_valid("bp_first");
                rdy_mode = 2;
                repeat (4) @(posedge clk);
                rdy_mode = 0;
            end
        join
        drain(100);

        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            r1 = $urandom;
            r2 = $urandom;
            if (r2[3:2] == 2'b00) begin
                @(posedge clk);
                #1;
            end
            send(r1[15:0], r1[31:16], r2[0]);
        end
        drain(3000);
        rdy_mode   = 0;
        lat_strict = 1'b1;

        rdy_mode = 2;
        @(posedge clk);
        #1;
        send(16'h1111, 16'h2222, 1'b0);
        send(16'h0F0F, 16'h0101, 1'b0);
        send(16'h4000, 16'h4000, 1'b0);
        wait_out_valid("rst_fill");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_flags", 32'({cout, ovf}), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        rdy_mode = 0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        send(16'h0002, 16'h0003, 1'b0);
        drain(50);
        repeat (8) @(posedge clk);

        chk("final_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
